store_buffer: RTL
=================

Name: store_buffer

Overview:
Parametrised store buffer between the pipeline's memory stage and the data-memory port. It carries the existing single write request (valid, addr, data, size, strobe) and generalises it into a DEPTH-entry in-order queue.
- Stores retire into the buffer without waiting for memory.
- Stores drain to memory through a valid/ready handshake.
- Load-address conflict detection is provided so loads never read stale memory.

Parameters:
DEPTH, 4, number of entries; power of two, >=2
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; strobe width SW = DATA_WIDTH/8

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
push_valid  in  1  store request valid
push_ready  out  1  buffer can accept a store
push_addr  in  ADDR_WIDTH  store address
push_data  in  DATA_WIDTH  store data, already lane-aligned
push_size  in  2  access size code (0 byte, 1 half, 2 word)
push_strobe  in  SW  byte-lane write enables
mem_valid  out  1  head entry presented to memory
mem_ready  in  1  memory accepts head entry
mem_addr  out  ADDR_WIDTH  head address
mem_data  out  DATA_WIDTH  head data
mem_size  out  2  head size
mem_strobe  out  SW  head strobe
ld_valid  in  1  load lookup valid
ld_addr  in  ADDR_WIDTH  load address
ld_conflict  out  1  load must stall
fwd_hit  out  1  load data forwarded (feature only)
fwd_data  out  DATA_WIDTH  forwarded data (feature only)
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Storage: circular array with head pointer, tail pointer and count.
- Reset (async, active-high):
  - head = tail = count = 0; all entry fields = 0.
  - mem_valid=0; mem_addr/mem_data/mem_size/mem_strobe = 0.
  - push_ready=1, empty=1, ld_conflict=0, fwd_hit=0, fwd_data=0.
- Reset asserted mid-drain discards all entries; no partial drain survives reset.
- push_ready = (count != DEPTH). It is not combinationally dependent on mem_ready: no bypass when full.
- Push fires when push_valid && push_ready. The entry is written at tail and tail wraps modulo DEPTH.
- Push with push_strobe==0: accepted (handshake completes) but not enqueued; count unchanged.
- Pop fires when mem_valid && mem_ready. Head advances modulo DEPTH.
- mem_valid = !empty; mem_* fields are the head entry, driven directly from storage (not through a further register).
- Latency: a store pushed in cycle N appears on mem_* in cycle N+1 at the earliest (empty buffer).
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any count < DEPTH.
- When full, a pop frees the slot for the next cycle only.
- Ordering: strictly FIFO. Memory sees stores in push order with no merging.
- ld_conflict is combinational. It asserts when ld_valid and any occupied entry (head included, even if popping this cycle) satisfies both:
  - addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2], and
  - strobe != 0.
- A store pushed in the same cycle as the lookup is not visible to the lookup; the pipeline handles that hazard.
- ld_valid=0 forces ld_conflict=0 and fwd_hit=0.

Optional Feature:
STORE_BUFFER_FWD_EN
- Defined:
  - Find the youngest occupied entry matching the load word address.
  - If its strobe is all ones: fwd_hit=1, fwd_data = its data, ld_conflict=0.
  - Otherwise (partial strobe): ld_conflict=1, fwd_hit=0.
- Undefined: fwd_hit and fwd_data are tied to 0; ld_conflict asserts on any match, as specified above.

Test Plan:
- Reset, then push addr=0x1000 data=0xDEADBEEF strobe=4'hF with mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x1000, mem_data=0xDEADBEEF, count=1.
- Push 4 stores (addr 0x0,0x4,0x8,0xC) with mem_ready=0 -> push_ready=0 after the 4th, count=4. Raise mem_ready -> drained in order 0x0,0x4,0x8,0xC; a 5th push accepted only after the first pop.
- Hold buffer at count=2; push_valid and mem_ready both high for 6 cycles -> count stays 2; memory order matches push order across pointer wrap.
- Push strobe=4'h0 -> push handshake completes, count stays 0, mem_valid stays 0.
- Buffer holds 0x2000/strobe 4'h1 and 0x2000/strobe 4'hF (younger, data 0x12345678):
  - ld_addr=0x2002 -> ld_conflict=1 without the feature; with STORE_BUFFER_FWD_EN, fwd_hit=1, fwd_data=0x12345678, ld_conflict=0.
  - ld_addr=0x3000 -> ld_conflict=0.
- Assert reset while count=3 and mem_valid=1 -> immediately mem_valid=0, count=0, empty=1; after release, the first push is presented normally.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store buffer between the memory stage and the data-memory port, with load-conflict lookup.
// Define STORE_BUFFER_FWD_EN to forward full-word data from the youngest matching store.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            push_size,
  input  logic [SW-1:0]         push_strobe,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [1:0]            mem_size,
  output logic [SW-1:0]         mem_strobe,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_conflict,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_d   [DEPTH];
  logic [1:0]            size_q   [DEPTH];
  logic [1:0]            size_d   [DEPTH];
  logic [SW-1:0]         strobe_q [DEPTH];
  logic [SW-1:0]         strobe_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  enq, pop;
  logic                  ld_addr_unused;

  assign ld_addr_unused = ^ld_addr[1:0];

  assign push_ready = (count_q != CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign mem_valid  = !empty;
  assign mem_addr   = addr_q[head_q];
  assign mem_data   = data_q[head_q];
  assign mem_size   = size_q[head_q];
  assign mem_strobe = strobe_q[head_q];

  // A push with no enabled lanes completes its handshake but never occupies a slot.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    enq      = push_valid && push_ready && (push_strobe != '0);
    pop      = mem_valid && mem_ready;
    if (enq) begin
      addr_d[tail_q]   = push_addr;
      data_d[tail_q]   = push_data;
      size_d[tail_q]   = push_size;
      strobe_d[tail_q] = push_strobe;
      tail_d           = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (enq && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!enq && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        size_q[i]   <= '0;
        strobe_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
    end
  end

  // Walk from head towards tail so the last match found is the youngest store.
  always_comb begin
    logic          match_any;
    logic [PW-1:0] idx;
`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] young_idx;
    young_idx = '0;
`endif
    match_any   = 1'b0;
    idx         = '0;
    ld_conflict = 1'b0;
    fwd_hit     = 1'b0;
    fwd_data    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (addr_q[idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) &&
          (strobe_q[idx] != '0)) begin
        match_any = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young_idx = idx;
`endif
      end
    end
    if (ld_valid && match_any) begin
`ifdef STORE_BUFFER_FWD_EN
      if (&strobe_q[young_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[young_idx];
      end else begin
        ld_conflict = 1'b1;
      end
`else
      ld_conflict = 1'b1;
`endif
    end
  end

endmodule
